// File: rtl/signal_capture_fifo.sv
// Pin-change capture: timestamped change/wrap records buffered in a FIFO and serialised as bytes for SPI.
// Optional start trigger enabled by defining SIGNAL_CAPTURE_TRIGGER_EN.
module signal_capture_fifo #(
    parameter int CHANNELS   = 8,
    parameter int TIME_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CHANNELS-1:0]      pin_values,
    output logic [7:0]               tx_byte,
    output logic                     tx_valid,
    input  logic                     tx_next,
    input  logic [CHANNELS-1:0]      trig_mask,
    input  logic [CHANNELS-1:0]      trig_value,
    output logic                     triggered,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int VB = (CHANNELS + 7) / 8;
    localparam int TB = TIME_WIDTH / 8;
    localparam int NB = TB + VB;
    localparam int RW = NB * 8;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = $clog2(NB);
    localparam logic [TIME_WIDTH-1:0] D_MAX    = '1;
    localparam logic [LW-1:0]         FULL     = LW'(DEPTH);
    localparam logic [IW-1:0]         LAST_IDX = IW'(NB - 1);

    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_nx;

    logic [CHANNELS-1:0]   s1, s, last;
    logic [TIME_WIDTH-1:0] d;
    logic [RW-1:0]         mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [LW-1:0]         count;
    logic [RW-1:0]         sh;
    logic [IW-1:0]         idx;
    logic [VB*8-1:0]       s_ext, last_ext;
    logic [RW-1:0]         rec;
    logic                  trig, fire, want, push, pop;

    always_comb begin
        s_ext    = '0;
        last_ext = '0;
        s_ext[CHANNELS-1:0]    = s;
        last_ext[CHANNELS-1:0] = last;
    end

`ifdef SIGNAL_CAPTURE_TRIGGER_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      trig <= 1'b0;
        else if (fire) trig <= 1'b1;
    end
`else
    assign trig = 1'b1;
    wire unused_trig = &{1'b0, trig_mask, trig_value};
`endif
    assign triggered = trig;

    // Record selection: trigger record, then change, then wrap.
    always_comb begin
        want = 1'b0;
        fire = 1'b0;
        rec  = '0;
`ifdef SIGNAL_CAPTURE_TRIGGER_EN
        if (!trig && ((s & trig_mask) == (trig_value & trig_mask))) begin
            fire = 1'b1;
            want = 1'b1;
            rec  = {{TIME_WIDTH{1'b0}}, s_ext};
        end else
`endif
        if (trig && s != last) begin
            want = 1'b1;
            rec  = {d, s_ext};
        end else if (trig && d == D_MAX) begin
            want = 1'b1;
            rec  = {D_MAX, last_ext};
        end
    end

    assign pop  = (state == IDLE) && (count != '0);
    assign push = want && ((count != FULL) || pop);

    // d restarts at 1 after a push so the next record carries the true cycle distance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1       <= '0;
            s        <= '0;
            last     <= '0;
            d        <= '0;
            overflow <= 1'b0;
        end else begin
            s1 <= pin_values;
            s  <= s1;
            if (push) begin
                last <= s;
                d    <= TIME_WIDTH'(1);
            end else if (d != D_MAX) begin
                d <= d + 1'b1;
            end
            if (want && !push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rec;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + LW'(push) - LW'(pop);
        end
    end
    assign fifo_level = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (count != '0) state_nx = SEND;
            SEND: if (tx_next && idx == LAST_IDX) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Shift register presents the record MSB byte first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh  <= '0;
            idx <= '0;
        end else if (pop) begin
            sh  <= mem[rd_ptr];
            idx <= '0;
        end else if (state == SEND && tx_next) begin
            sh  <= sh << 8;
            idx <= idx + 1'b1;
        end
    end

    assign tx_valid = (state == SEND);
    assign tx_byte  = sh[RW-1 -: 8];
endmodule
